mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache/dcache) arbiter onto a single word RAM with dcache priority and icache starvation guard
//   CLK/RST            clock, async active-high reset
//   iREN/iaddr         icache read request/address; iwait/iload response
//   dREN/dWEN/daddr    dcache request/address, dstore write data; dwait/dload response
//   ramREN/ramWEN      RAM strobes, ramaddr/ramstore to RAM, ramload/ramstate from RAM
//   err                sticky: RAM reported ERROR during an active grant
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic dreq, dact, iact, acc;
  always_comb begin
    dreq = dREN | dWEN;
    dact = state_q == DGNT && dreq;
    iact = state_q == IGNT && iREN;
    acc = ramstate == 2'b10;
    cnt_d = (!iREN || (iact && acc)) ? '0
          : (dact && acc && cnt_q != CW'(STARVE_LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    // arbitration sees the count including this cycle's completion, so the limit-th dcache word hands over at once
    state_d = ((dact || iact) && !acc) ? state_q
            : (dreq && !(iREN && cnt_d == CW'(STARVE_LIMIT))) ? DGNT
            : iREN ? IGNT : IDLE;
    err_d = err_q | ((dact || iact) && ramstate == 2'b11);
    ramWEN = dact && dWEN;
    ramREN = (dact && !dWEN) || iact;
    ramaddr = dact ? daddr : iact ? iaddr : '0;
    ramstore = ramWEN ? dstore : '0;
    dwait = !(dact && acc);
    iwait = !(iact && acc);
    dload = (dact && acc && !dWEN) ? ramload : '0;
    iload = (iact && acc) ? ramload : '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;
  logic CLK = 0, RST = 1;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = 0;
  logic iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int errors = 0, checks = 0;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  wire [132:0] act = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, err};

  function automatic logic [132:0] ex(logic ren, logic wen, logic [31:0] addr, logic [31:0] store,
                                      logic iw, logic dw, logic [31:0] il, logic [31:0] dl, logic e);
    return {ren, wen, addr, store, iw, dw, il, dl, e};
  endfunction

  task automatic chk(string n, logic [132:0] a, logic [132:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  typedef struct {
    logic iren;
    logic [31:0] iaddr;
    logic dren, dwen;
    logic [31:0] daddr, dstore, ramload;
    logic [1:0] rs;
    logic [132:0] exp;
  } vec_t;

  vec_t v[15];
  logic [132:0] idle_exp;
  string pat;

  initial begin
    idle_exp = ex(0, 0, 0, 0, 1, 1, 0, 0, 0);
    v[0]  = '{1, 32'h40, 0, 0, 0, 0, 0, FREE, idle_exp};
    v[1]  = '{1, 32'h40, 0, 0, 0, 0, 32'h11111111, ACC, ex(1, 0, 32'h40, 0, 0, 1, 32'h11111111, 0, 0)};
    v[2]  = '{0, 32'h40, 0, 0, 0, 0, 32'h99, ACC, idle_exp};
    v[3]  = '{1, 32'h40, 1, 0, 32'h100, 0, 0, BUSY, idle_exp};
    v[4]  = '{1, 32'h40, 1, 0, 32'h100, 0, 0, BUSY, ex(1, 0, 32'h100, 0, 1, 1, 0, 0, 0)};
    v[5]  = '{1, 32'h40, 1, 0, 32'h100, 0, 0, BUSY, ex(1, 0, 32'h100, 0, 1, 1, 0, 0, 0)};
    v[6]  = '{1, 32'h40, 1, 0, 32'h100, 0, 32'hDEADBEEF, ACC, ex(1, 0, 32'h100, 0, 1, 0, 0, 32'hDEADBEEF, 0)};
    v[7]  = '{0, 0, 1, 1, 32'h3100, 32'h7, 0, BUSY, ex(0, 1, 32'h3100, 32'h7, 1, 1, 0, 0, 0)};
    v[8]  = '{0, 0, 1, 1, 32'h3100, 32'h7, 32'hAAAA5555, ACC, ex(0, 1, 32'h3100, 32'h7, 1, 0, 0, 0, 0)};
    v[9]  = '{0, 0, 1, 0, 32'h104, 0, 32'h12345678, ACC, ex(1, 0, 32'h104, 0, 1, 0, 0, 32'h12345678, 0)};
    v[10] = '{1, 32'h200, 0, 0, 32'h104, 0, 32'h55, ACC, idle_exp};
    v[11] = '{1, 32'h200, 0, 0, 0, 0, 0, ERR, ex(1, 0, 32'h200, 0, 1, 1, 0, 0, 0)};
    v[12] = '{1, 32'h200, 0, 0, 0, 0, 32'hCAFEF00D, ACC, ex(1, 0, 32'h200, 0, 0, 1, 32'hCAFEF00D, 0, 1)};
    v[13] = '{0, 0, 0, 0, 0, 0, 0, FREE, ex(0, 0, 0, 0, 1, 1, 0, 0, 1)};
    v[14] = '{0, 0, 0, 0, 0, 0, 0, FREE, ex(0, 0, 0, 0, 1, 1, 0, 0, 1)};

    iREN = 1; iaddr = 32'h40;
    repeat (2) @(negedge CLK);
    #2 chk("reset", act, idle_exp);
    @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 15; i++) begin
      iREN = v[i].iren; iaddr = v[i].iaddr; dREN = v[i].dren; dWEN = v[i].dwen;
      daddr = v[i].daddr; dstore = v[i].dstore; ramload = v[i].ramload; ramstate = v[i].rs;
      #2 chk($sformatf("vec%0d", i), act, v[i].exp);
      @(negedge CLK);
    end

    iREN = 0; dREN = 1; dWEN = 0; daddr = 32'h500; ramstate = BUSY; ramload = 0;
    @(negedge CLK);
    #2 chk("pre_abort_grant", act, ex(1, 0, 32'h500, 0, 1, 1, 0, 0, 1));
    #1 RST = 1;
    #1 chk("async_abort", act, idle_exp);
    @(negedge CLK);
    RST = 0;
    #2 chk("no_strobe_after_release", act, idle_exp);
    @(negedge CLK);
    #2 chk("regrant_after_release", act, ex(1, 0, 32'h500, 0, 1, 1, 0, 0, 0));
    @(negedge CLK);

    iREN = 1; iaddr = 32'h40; daddr = 32'h100; ramstate = ACC; ramload = 32'h0BADF00D;
    pat = "DDDDIDDDDI";
    for (int c = 0; c < 10; c++) begin
      logic [1:0] got, want;
      #2;
      got = {!dwait, !iwait};
      want = (pat[c] == "D") ? 2'b10 : 2'b01;
      chk($sformatf("starve%0d", c), {131'd0, got}, {131'd0, want});
      @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
